// File: rtl/stch2dec_window.sv
// Stochastic-to-decimal converter. It counts the 1s in a stochastic bit stream over a
// window of 2^NW enabled samples. At the end of each window it reports the estimate as
// an ND-bit fraction, together with a one-cycle valid pulse.
module stch2dec_window #(
  parameter int unsigned ND   = 8,    // output fraction width, result scaled to x/2^ND
  parameter int unsigned NW   = 8,    // log2 of window length; NW >= ND
  parameter bit          CONT = 1'b0  // 1: back-to-back windows, 0: one-shot per start
) (
  input  logic          clk_i,
  input  logic          init_i,   // synchronous active-high reset
  input  logic          start_i,
  input  logic          en_i,
  input  logic          s_i,
  output logic [ND-1:0] d_o,
  output logic          valid_o,
  output logic          busy_o
);

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  state_e        state_q;
  logic [NW:0]   ones_q;    // holds 0..2^NW
  logic [NW-1:0] win_q;     // enabled samples taken so far in this window
  logic [ND-1:0] d_q;
  logic          valid_q;
  logic          busy_q;

  logic [NW:0]   total;
  logic          last_sample;
  logic [ND-1:0] est;

  // Window total including the current sample, and the scaled and saturated estimate
  always_comb begin
    total       = ones_q + {{NW{1'b0}}, s_i};
    last_sample = en_i && (win_q == {NW{1'b1}});
    // The top bit is set only when every sample was 1 (total == 2^NW). The
    // estimate clamps to all ones there instead of wrapping to zero.
    if (total[NW]) begin
      est = {ND{1'b1}};
    end else begin
      est = total[NW-1 -: ND];
    end
  end

  // Control FSM with registered outputs; init overrides every other input
  always_ff @(posedge clk_i) begin
    if (init_i) begin
      state_q <= StIdle;
      ones_q  <= '0;
      win_q   <= '0;
      d_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // The sample on the start edge is deliberately not counted
          if (start_i) begin
            state_q <= StAccum;
            ones_q  <= '0;
            win_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StAccum: begin
          if (last_sample) begin
            d_q     <= est;
            valid_q <= 1'b1;
            ones_q  <= '0;
            win_q   <= '0;
            if (!CONT) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end else if (en_i) begin
            ones_q <= total;
            win_q  <= win_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign d_o     = d_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_stch2dec_window.sv
// Directed bench for stch2dec_window: one-shot windows with several stream shapes, EN gaps,
// abort by init, ignored start, and a continuous-mode instance.
module tb_stch2dec_window;

  logic       clk;
  logic       init, start, en, s;
  logic [7:0] d;
  logic       valid, busy;

  logic       init2, start2, en2, s2;
  logic [7:0] d2;
  logic       valid2, busy2;

  int checks = 0;
  int errors = 0;

  stch2dec_window #(.ND(8), .NW(8), .CONT(1'b0)) u_dut (
    .clk_i   (clk),
    .init_i  (init),
    .start_i (start),
    .en_i    (en),
    .s_i     (s),
    .d_o     (d),
    .valid_o (valid),
    .busy_o  (busy)
  );

  stch2dec_window #(.ND(8), .NW(8), .CONT(1'b1)) u_dut_cont (
    .clk_i   (clk),
    .init_i  (init2),
    .start_i (start2),
    .en_i    (en2),
    .s_i     (s2),
    .d_o     (d2),
    .valid_o (valid2),
    .busy_o  (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one window on u_dut. Modes: 0 s=0, 1 s=1, 2 every 4th sample, 3 LFSR at 0x40,
  // 4 EN toggling with s=~en. lat counts edges after the start edge until valid is seen.
  task automatic do_window(input int mode, input bit mid_start, output int lat,
                           output logic [7:0] dval, output logic busy_mid);
    logic [7:0] lfsr;
    int cyc;
    int k;
    lfsr = 8'h01;
    start = 1'b1; en = 1'b1; s = 1'b0;
    tick();
    start = 1'b0;
    cyc = 0; k = 0; lat = -1; busy_mid = 1'b0;
    while (cyc < 2000 && lat < 0) begin
      en = (mode == 4) ? (cyc % 2 == 1) : 1'b1;
      case (mode)
        0:       s = 1'b0;
        1:       s = 1'b1;
        2:       s = (k % 4 == 0);
        3:       s = (lfsr < 8'h40);
        default: s = ~en;
      endcase
      start = mid_start && (cyc == 50);
      tick();
      cyc++;
      if (en) begin
        k++;
        lfsr = lfsr[0] ? ((lfsr >> 1) ^ 8'hB8) : (lfsr >> 1);
      end
      if (cyc == 10) busy_mid = busy;
      if (valid) lat = cyc;
    end
    start = 1'b0; en = 1'b0; s = 1'b0;
    dval = d;
  endtask

  task automatic test_reset();
    init = 1'b1; start = 1'b1; en = 1'b1; s = 1'b1;
    init2 = 1'b1; start2 = 1'b0; en2 = 1'b0; s2 = 1'b0;
    tick(); tick();
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_d got %h want 00", d); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    init = 1'b0; start = 1'b0; init2 = 1'b0;
    tick();
    // start was high alongside init: must still be idle
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL init_start_busy got %b want 0", busy); end
  endtask

  task automatic test_zero_stream();
    int lat; logic [7:0] dv; logic bm;
    do_window(0, 1'b0, lat, dv, bm);
    checks++; if (lat !== 256) begin errors++; $display("FAIL zero_latency got %0d want 256", lat); end
    checks++; if (dv !== 8'h00) begin errors++; $display("FAIL zero_d got %h want 00", dv); end
    checks++; if (bm !== 1'b1) begin errors++; $display("FAIL zero_busy_mid got %b want 1", bm); end
    tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL zero_valid_width got %b want 0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_after got %b want 0", busy); end
  endtask

  task automatic test_saturate();
    int lat; int pulses; logic [7:0] dv; logic bm;
    do_window(1, 1'b0, lat, dv, bm);
    checks++; if (dv !== 8'hFF) begin errors++; $display("FAIL sat_d got %h want ff", dv); end
    pulses = 0;
    en = 1'b1; s = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (valid) pulses++;
    end
    en = 1'b0; s = 1'b0;
    checks++; if (pulses !== 0) begin errors++; $display("FAIL sat_extra_valid got %0d want 0", pulses); end
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL sat_d_hold got %h want ff", d); end
  endtask

  task automatic test_quarter();
    int lat; logic [7:0] dv; logic bm;
    do_window(2, 1'b0, lat, dv, bm);
    checks++; if (dv !== 8'h40) begin errors++; $display("FAIL quarter_d got %h want 40", dv); end
    do_window(3, 1'b0, lat, dv, bm);
    checks++;
    if (dv < 8'h3F || dv > 8'h41) begin
      errors++; $display("FAIL lfsr_d got %h want 40+/-1", dv);
    end
  endtask

  task automatic test_en_gaps();
    int lat; logic [7:0] dv; logic bm;
    do_window(4, 1'b0, lat, dv, bm);
    checks++; if (lat !== 512) begin errors++; $display("FAIL gap_latency got %0d want 512", lat); end
    checks++; if (dv !== 8'h00) begin errors++; $display("FAIL gap_d got %h want 00", dv); end
  endtask

  task automatic test_start_ignored();
    int lat; logic [7:0] dv; logic bm;
    do_window(2, 1'b1, lat, dv, bm);
    checks++; if (lat !== 256) begin errors++; $display("FAIL midstart_latency got %0d want 256", lat); end
    checks++; if (dv !== 8'h40) begin errors++; $display("FAIL midstart_d got %h want 40", dv); end
  endtask

  task automatic test_abort();
    int pulses;
    start = 1'b1; en = 1'b1; s = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %b want 1", busy); end
    init = 1'b1;
    tick();
    init = 1'b0;
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL abort_d got %h want 00", d); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    pulses = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (valid) pulses++;
    end
    en = 1'b0; s = 1'b0;
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_late_valid got %0d want 0", pulses); end
  endtask

  task automatic test_back_to_back();
    int cyc; int k; int nv; int busy_drops;
    int v_at [2];
    logic [7:0] v_d [2];
    start2 = 1'b1; en2 = 1'b1; s2 = 1'b0;
    tick();
    start2 = 1'b0;
    cyc = 0; k = 0; nv = 0; busy_drops = 0;
    v_at[0] = -1; v_at[1] = -1; v_d[0] = 8'h00; v_d[1] = 8'h00;
    while (cyc < 1200 && nv < 2) begin
      s2 = (k < 256);
      tick();
      cyc++; k++;
      if (busy2 !== 1'b1) busy_drops++;
      if (valid2) begin
        v_at[nv] = cyc; v_d[nv] = d2; nv++;
      end
    end
    en2 = 1'b0; s2 = 1'b0;
    checks++; if (v_at[0] !== 256) begin errors++; $display("FAIL cont_first_at got %0d want 256", v_at[0]); end
    checks++;
    if (v_at[1] - v_at[0] !== 256) begin
      errors++; $display("FAIL cont_spacing got %0d want 256", v_at[1] - v_at[0]);
    end
    checks++; if (v_d[0] !== 8'hFF) begin errors++; $display("FAIL cont_d1 got %h want ff", v_d[0]); end
    checks++; if (v_d[1] !== 8'h00) begin errors++; $display("FAIL cont_d2 got %h want 00", v_d[1]); end
    checks++; if (busy_drops !== 0) begin errors++; $display("FAIL cont_busy_drops got %0d want 0", busy_drops); end
  endtask

  initial begin
    init = 1'b1; start = 1'b0; en = 1'b0; s = 1'b0;
    init2 = 1'b1; start2 = 1'b0; en2 = 1'b0; s2 = 1'b0;
    test_reset();
    test_zero_stream();
    test_saturate();
    test_quarter();
    test_en_gaps();
    test_start_ignored();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
